// File: rtl/ntt_stage_sequencer_if.sv
// Start/count handshake between the NTT stage sequencer (master) and the stage datapath (slave).
// The stall signal exists only when NTT_SEQ_STALL_EN is defined.
interface ntt_stage_sequencer_if #(
    parameter int STG_W = 4,
    parameter int CNT_W = 4
);
    logic             go;
    logic             abort;
`ifdef NTT_SEQ_STALL_EN
    logic             stall;
`endif
    logic             stage_start;
    logic [STG_W-1:0] stage_idx;
    logic [CNT_W-1:0] cyc_cnt;
    logic             busy;
    logic             done;
    logic             err_go_busy;

`ifdef NTT_SEQ_STALL_EN
    modport master (
        input  go, abort, stall,
        output stage_start, stage_idx, cyc_cnt, busy, done, err_go_busy
    );
    modport slave (
        output go, abort, stall,
        input  stage_start, stage_idx, cyc_cnt, busy, done, err_go_busy
    );
`else
    modport master (
        input  go, abort,
        output stage_start, stage_idx, cyc_cnt, busy, done, err_go_busy
    );
    modport slave (
        output go, abort,
        input  stage_start, stage_idx, cyc_cnt, busy, done, err_go_busy
    );
`endif
endinterface

// File: rtl/ntt_stage_sequencer.sv
// Issues one stage_start pulse per NTT stage with drain gaps between stages, then pulses done.
// Define NTT_SEQ_STALL_EN to add the stall input that freezes sequencing in RUN/GAP.
module ntt_stage_sequencer #(
    parameter int STAGE_CYCLES = 16,
    parameter int NUM_STAGES   = 11,
    parameter int GAP_CYCLES   = 2,
    parameter int STG_W        = 4,
    parameter int CNT_W        = 4
) (
    input logic                   clk,
    input logic                   rst,
    ntt_stage_sequencer_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [STG_W-1:0] STG_LAST   = STG_W'(NUM_STAGES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [STG_W-1:0] STG_ONE    = STG_W'(1);

    logic [1:0]       state;
    logic             stage_start;
    logic [STG_W-1:0] stage_idx;
    logic [CNT_W-1:0] cyc_cnt;
    logic             busy;
    logic             done;
    logic             err_go_busy;
    logic             stalled;
    logic             go_ok;

`ifdef NTT_SEQ_STALL_EN
    assign stalled = bus.stall;
`else
    assign stalled = 1'b0;
`endif

    // abort always beats go, even in IDLE and DONE
    assign go_ok = bus.go && !bus.abort;

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it sits inside the clocked branch rather than the sensitivity list.
        if (rst) begin
            state       <= IDLE;
            stage_start <= 1'b0;
            stage_idx   <= '0;
            cyc_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_go_busy <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every branch below sees pre-edge register values.
            stage_start <= 1'b0;
            done        <= 1'b0;
            if (go_ok && (state == RUN || state == GAP))
                err_go_busy <= 1'b1;

            case (state)
                IDLE: begin
                    if (go_ok) begin
                        state       <= RUN;
                        stage_start <= 1'b1;
                        stage_idx   <= '0;
                        cyc_cnt     <= '0;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        stage_idx <= '0;
                        cyc_cnt   <= '0;
                        busy      <= 1'b0;
                    end else if (!stalled) begin
                        if (cyc_cnt == STAGE_LAST) begin
                            if (stage_idx == STG_LAST) begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else if (GAP_CYCLES == 0) begin
                                stage_idx   <= stage_idx + STG_ONE;
                                cyc_cnt     <= '0;
                                stage_start <= 1'b1;
                            end else begin
                                state   <= GAP;
                                cyc_cnt <= '0;
                            end
                        end else begin
                            cyc_cnt <= cyc_cnt + CNT_ONE;
                        end
                    end
                end
                GAP: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        stage_idx <= '0;
                        cyc_cnt   <= '0;
                        busy      <= 1'b0;
                    end else if (!stalled) begin
                        if (cyc_cnt == GAP_LAST) begin
                            state       <= RUN;
                            stage_idx   <= stage_idx + STG_ONE;
                            cyc_cnt     <= '0;
                            stage_start <= 1'b1;
                        end else begin
                            cyc_cnt <= cyc_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    // DONE lasts one cycle; a fresh go restarts with no dead cycle
                    if (go_ok) begin
                        state       <= RUN;
                        stage_start <= 1'b1;
                        stage_idx   <= '0;
                        cyc_cnt     <= '0;
                        busy        <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        stage_idx <= '0;
                        cyc_cnt   <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.stage_start = stage_start;
    assign bus.stage_idx   = stage_idx;
    assign bus.cyc_cnt     = cyc_cnt;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.err_go_busy = err_go_busy;
endmodule
